// File: rtl/alu_seq_div_pkg.sv
// Shared definitions for the sequential divider.
//   ALU_DEF_WIDTH : default operand/result width
//   div_state_e   : controller state encoding (IDLE/CALC/SIGN)
package alu_seq_div_pkg;

    localparam int ALU_DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } div_state_e;

endpackage : alu_seq_div_pkg

// File: rtl/alu_seq_div_if.sv
// Request/response bundle of the sequential divider.
//   start, signed_op, dividend, divisor : request side (driven by master)
//   busy, done, quotient, remainder,
//   div_by_zero                         : response side (driven by slave)
interface alu_seq_div_if
    import alu_seq_div_pkg::*;
#(
    parameter int WIDTH = ALU_DEF_WIDTH
) ();

    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, signed_op, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, signed_op, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface : alu_seq_div_if

// File: rtl/alu_div_step.sv
// One restoring shift-subtract iteration (purely combinational).
//   rem_in       : current partial remainder (always < divisor)
//   dividend_bit : next dividend bit, shifted in at the LSB
//   divisor      : divisor magnitude
//   rem_out      : next partial remainder
//   q_bit        : quotient bit produced by this step
module alu_div_step
    import alu_seq_div_pkg::*;
#(
    parameter int WIDTH = ALU_DEF_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Because rem_in < divisor, shifted < 2*divisor: a successful
    // subtraction always leaves bit WIDTH clear, a failed one sets it.
    always_comb begin
        shifted = {rem_in, dividend_bit};
        diff    = shifted - {1'b0, divisor};
        q_bit   = ~diff[WIDTH];
        rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule : alu_div_step

// File: rtl/alu_seq_div.sv
// Sequential radix-2 restoring divider, signed or unsigned.
//   clk, resetn : clock, asynchronous active-low reset
//   bus (slave) : start/signed_op/dividend/divisor in;
//                 busy/done/quotient/remainder/div_by_zero out (registered)
// Operands are converted to magnitudes on acceptance, WIDTH iterations run
// in CALC (one quotient bit per cycle, MSB first), and SIGN applies the
// result signs and publishes the outputs with a one-cycle done pulse.
module alu_seq_div
    import alu_seq_div_pkg::*;
#(
    parameter int WIDTH = ALU_DEF_WIDTH
) (
    input  logic         clk,
    input  logic         resetn,
    alu_seq_div_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_e       state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [WIDTH-1:0] acc_q,       acc_d;       // partial remainder
    logic [WIDTH-1:0] quo_q,       quo_d;       // dividend bits out, quotient bits in
    logic [WIDTH-1:0] dvs_q,       dvs_d;       // divisor magnitude
    logic [WIDTH-1:0] dnd_q,       dnd_d;       // raw dividend, for divide-by-zero
    logic             neg_quo_q,   neg_quo_d;
    logic             neg_rem_q,   neg_rem_d;
    logic             dz_q,        dz_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;
    logic [WIDTH-1:0] quotient_q,  quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q,       dbz_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    function automatic logic [WIDTH-1:0] negate(input logic signed [WIDTH-1:0] v);
        return $unsigned(-v);
    endfunction

    // Most-negative input maps to its own bit pattern, which is the correct
    // unsigned magnitude 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? negate(v) : $unsigned(v);
    endfunction

    alu_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in       (acc_q),
        .dividend_bit (quo_q[WIDTH-1]),
        .divisor      (dvs_q),
        .rem_out      (step_rem),
        .q_bit        (step_q)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        dnd_d       = dnd_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        dz_d        = dz_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dnd_d     = bus.dividend;
                    dz_d      = (bus.divisor == '0);
                    neg_quo_d = bus.signed_op & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                    neg_rem_d = bus.signed_op & bus.dividend[WIDTH-1];
                    quo_d     = bus.signed_op ? magnitude(bus.dividend) : bus.dividend;
                    dvs_d     = bus.signed_op ? magnitude(bus.divisor)  : bus.divisor;
                    acc_d     = '0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = (bus.divisor == '0) ? SIGN : CALC;
                end
            end
            CALC: begin
                acc_d = step_rem;
                quo_d = {quo_q[WIDTH-2:0], step_q};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = SIGN;
                end
            end
            SIGN: begin
                if (dz_q) begin
                    quotient_d  = '1;
                    remainder_d = dnd_q;
                end else begin
                    quotient_d  = neg_quo_q ? negate(quo_q) : quo_q;
                    remainder_d = neg_rem_q ? negate(acc_q) : acc_q;
                end
                dbz_d   = dz_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            dnd_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            dz_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            dnd_q       <= dnd_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            dz_q        <= dz_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;

endmodule : alu_seq_div

// File: tb/tb_alu_seq_div.sv
module tb_alu_seq_div;

    localparam int W = 32;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    alu_seq_div_if #(.WIDTH(W)) bus ();

    alu_seq_div #(.WIDTH(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] prev_q = '0;
    logic [W-1:0] prev_r = '0;
    logic         prev_dz = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: truncating division as defined for two's-complement or
    // unsigned integers, with the divide-by-zero convention.
    function automatic void model(input logic sop, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz);
        longint sa, sb;
        if (b == '0) begin
            q = '1; r = a; dz = 1'b1;
            return;
        end
        dz = 1'b0;
        if (sop) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts an operation in the current cycle (caller sits #1 after an edge
    // with the DUT idle) and returns in the cycle done is high.
    // restart_at >= 0 re-pulses start with other operands at that cycle.
    task automatic do_op(input string tag, input logic sop, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int restart_at);
        logic [W-1:0] eq, er;
        logic         edz;
        int           n;
        int           exp_lat;
        bit           bad_busy;
        bit           bad_hold;
        model(sop, a, b, eq, er, edz);
        exp_lat = (b == '0) ? 1 : W + 1;

        bus.start = 1'b1; bus.signed_op = sop; bus.dividend = a; bus.divisor = b;
        tick();
        bus.start = 1'b0;
        bus.dividend = $urandom; bus.divisor = $urandom; bus.signed_op = 1'($urandom);

        n = 0; bad_busy = 0; bad_hold = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            if (bus.busy !== 1'b1) bad_busy = 1;
            if (bus.quotient !== prev_q || bus.remainder !== prev_r || bus.div_by_zero !== prev_dz)
                bad_hold = 1;
            if (n == restart_at) begin
                bus.start = 1'b1; bus.dividend = $urandom; bus.divisor = $urandom;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            n++;
        end
        bus.start = 1'b0;
        check({tag, ".busy_during"}, 64'(bad_busy), 64'(0));
        check({tag, ".hold_prev"},   64'(bad_hold), 64'(0));
        check({tag, ".latency"},     64'(n),        64'(exp_lat));
        check({tag, ".busy_at_done"},64'(bus.busy), 64'(0));
        check({tag, ".quotient"},    64'(bus.quotient),    64'(eq));
        check({tag, ".remainder"},   64'(bus.remainder),   64'(er));
        check({tag, ".dbz"},         64'(bus.div_by_zero), 64'(edz));
        prev_q = eq; prev_r = er; prev_dz = edz;
    endtask

    initial begin
        int           lat;
        bit           saw_done;
        logic [W-1:0] ra, rb;
        logic         rs;

        bus.start = 1'b0; bus.signed_op = 1'b0; bus.dividend = '0; bus.divisor = '0;

        // Reset state
        #2;
        check("rst.busy", 64'(bus.busy), 64'(0));
        check("rst.done", 64'(bus.done), 64'(0));
        check("rst.q",    64'(bus.quotient), 64'(0));
        check("rst.r",    64'(bus.remainder), 64'(0));
        check("rst.dz",   64'(bus.div_by_zero), 64'(0));
        tick(); tick();
        resetn = 1'b1;
        tick();

        // Directed cases
        do_op("u100_7", 1'b0, 32'd100, 32'd7, -1);
        tick();
        check("u100_7.done_pulse", 64'(bus.done), 64'(0));
        do_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, -1);
        do_op("u_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, -1);
        do_op("u5_0",   1'b0, 32'd5, 32'd0, -1);
        tick();
        check("u5_0.done_pulse", 64'(bus.done), 64'(0));
        do_op("s5_0",   1'b1, 32'd5, 32'd0, -1);
        do_op("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        do_op("s7_m2",  1'b1, 32'd7, 32'hFFFF_FFFE, -1);
        do_op("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, -1);
        do_op("u3_9",   1'b0, 32'd3, 32'd9, -1);

        // Start re-pulsed at cycle 10 is ignored; next op starts in done cycle
        do_op("restart", 1'b0, 32'd1000, 32'd33, 10);
        do_op("b2b",     1'b1, 32'hFFFF_FC18, 32'd33, -1);

        // Randomized operations
        for (int i = 0; i < 16; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom);
            case (i % 4)
                1: rb = 32'($urandom_range(1, 255));
                2: if (i % 8 == 2) rb = '0;
                3: rb = rs ? 32'hFFFF_FFFF : 32'($urandom_range(1, 15));
                default: ;
            endcase
            do_op($sformatf("rand%0d", i), rs, ra, rb, -1);
        end
        tick();

        // Reset in the middle of an operation
        bus.start = 1'b1; bus.signed_op = 1'b0; bus.dividend = 32'd12345; bus.divisor = 32'd11;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        resetn = 1'b0;
        #1;
        check("midrst.busy", 64'(bus.busy), 64'(0));
        check("midrst.done", 64'(bus.done), 64'(0));
        check("midrst.q",    64'(bus.quotient), 64'(0));
        check("midrst.r",    64'(bus.remainder), 64'(0));
        check("midrst.dz",   64'(bus.div_by_zero), 64'(0));
        tick();
        resetn = 1'b1;
        saw_done = 0;
        for (int i = 0; i < 45; i++) begin
            tick();
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) saw_done = 1;
        end
        check("midrst.no_done", 64'(saw_done), 64'(0));
        prev_q = '0; prev_r = '0; prev_dz = 1'b0;
        do_op("after_rst_9_3", 1'b0, 32'd9, 32'd3, -1);
        tick();

        lat = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_alu_seq_div
